// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the I2S ADC receive path.
//   SAMPLE_W_DEF   : default bits per channel sample
//   rx_state_e     : receiver FSM states (IDLE, SKIP, SHIFT, HOLD)
//   stereo_frame_t : one stereo frame {left, right} at the default width
// -----------------------------------------------------------------------------
package audio_pkg;

  localparam int SAMPLE_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SKIP  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic [SAMPLE_W_DEF-1:0] left;
    logic [SAMPLE_W_DEF-1:0] right;
  } stereo_frame_t;

endpackage

// File: rtl/i2s_sync.sv
// -----------------------------------------------------------------------------
// i2s_sync
// Brings the three codec lines into the system clock domain and derives the
// strobes the receiver FSM runs on.
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   bclk         : raw codec bit clock
//   adclrck      : raw codec left/right clock
//   adcdat       : raw codec serial data
//   bclk_rise    : one-cycle strobe, synchronized bclk went 0 -> 1
//   lrck_toggle  : one-cycle strobe, synchronized adclrck changed level
//   lrck_sync    : synchronized adclrck level
//   dat_sync     : synchronized adcdat
// All three lines use the same number of stages, so data and clock edges keep
// their relative alignment after synchronization.
// -----------------------------------------------------------------------------
module i2s_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bclk,
  input  logic adclrck,
  input  logic adcdat,
  output logic bclk_rise,
  output logic lrck_toggle,
  output logic lrck_sync,
  output logic dat_sync
);

  logic [SYNC_STAGES-1:0] bclk_ff;
  logic [SYNC_STAGES-1:0] lrck_ff;
  logic [SYNC_STAGES-1:0] dat_ff;
  logic                   bclk_prev;
  logic                   lrck_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_ff   <= '0;
      lrck_ff   <= '0;
      dat_ff    <= '0;
      bclk_prev <= 1'b0;
      lrck_prev <= 1'b0;
    end else begin
      bclk_ff[0] <= bclk;
      lrck_ff[0] <= adclrck;
      dat_ff[0]  <= adcdat;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        bclk_ff[i] <= bclk_ff[i-1];
        lrck_ff[i] <= lrck_ff[i-1];
        dat_ff[i]  <= dat_ff[i-1];
      end
      bclk_prev <= bclk_ff[SYNC_STAGES-1];
      lrck_prev <= lrck_ff[SYNC_STAGES-1];
    end
  end

  assign bclk_rise   = bclk_ff[SYNC_STAGES-1] & ~bclk_prev;
  assign lrck_toggle = lrck_ff[SYNC_STAGES-1] ^ lrck_prev;
  assign lrck_sync   = lrck_ff[SYNC_STAGES-1];
  assign dat_sync    = dat_ff[SYNC_STAGES-1];

endmodule

// File: rtl/audio_adc_rx.sv
// -----------------------------------------------------------------------------
// audio_adc_rx
// I2S ADC receiver: deserializes left/right words from a codec and presents
// them as stereo frames on a valid/ready output.
// Ports:
//   clk_50       : system clock, all logic runs here
//   ar           : asynchronous active-low reset
//   bclk         : codec bit clock (asynchronous, <= clk_50/8)
//   adclrck      : codec L/R clock, low = left slot, high = right slot
//   adcdat       : codec serial data, I2S, MSB first
//   frame_ready  : consumer accepts the held frame
//   left_out     : left sample, two's complement
//   right_out    : right sample, two's complement
//   frame_valid  : a stereo frame is held on left_out/right_out
//   overrun      : sticky, a completed frame was dropped
//   overrun_clr  : clears overrun (a simultaneous set wins)
//   crush        : (only with AUDIO_ADC_RX_BITCRUSH_EN) number of low bits
//                  zeroed in both samples when a frame is loaded
//   fsm_state    : current receiver FSM state, for observation
// Build option: define AUDIO_ADC_RX_BITCRUSH_EN to add the crush input.
//
// Output handshake: a frame transfers on any cycle where frame_valid and
// frame_ready are both high. left_out/right_out never change while
// frame_valid is high, except on the transfer cycle itself when a newly
// completed frame replaces the one just taken. frame_valid drops after a
// transfer unless such a replacement happens.
// -----------------------------------------------------------------------------
module audio_adc_rx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W    = SAMPLE_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_50,
  input  logic                ar,
  input  logic                bclk,
  input  logic                adclrck,
  input  logic                adcdat,
  input  logic                frame_ready,
`ifdef AUDIO_ADC_RX_BITCRUSH_EN
  input  logic [3:0]          crush,
`endif
  output logic [SAMPLE_W-1:0] left_out,
  output logic [SAMPLE_W-1:0] right_out,
  output logic                frame_valid,
  output logic                overrun,
  input  logic                overrun_clr,
  output rx_state_e           fsm_state
);

  localparam int                CNT_W    = $clog2(SAMPLE_W + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(SAMPLE_W - 1);

  // Synchronized codec view
  logic bclk_rise;
  logic lrck_toggle;
  logic lrck_sync;
  logic dat_sync;

  i2s_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk         (clk_50),
    .rst_n       (ar),
    .bclk        (bclk),
    .adclrck     (adclrck),
    .adcdat      (adcdat),
    .bclk_rise   (bclk_rise),
    .lrck_toggle (lrck_toggle),
    .lrck_sync   (lrck_sync),
    .dat_sync    (dat_sync)
  );

  // FSM and datapath state
  rx_state_e          state;
  rx_state_e          state_next;
  logic [CNT_W-1:0]   bit_cnt;
  logic [SAMPLE_W-1:0] shreg;
  logic [SAMPLE_W-1:0] shreg_shifted;
  logic               chan;        // 0 = left, 1 = right
  logic [SAMPLE_W-1:0] left_buf;
  logic               left_valid;  // left word from the current/previous left slot

  // FSM control strobes
  logic latch_chan;
  logic cnt_clr;
  logic shift_en;
  logic word_done;

  logic frame_done;
  logic xfer;
  logic [SAMPLE_W-1:0] crush_mask;

  assign fsm_state     = state;
  assign shreg_shifted = {shreg[SAMPLE_W-2:0], dat_sync};

  always_ff @(posedge clk_50 or negedge ar) begin
    if (!ar) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // An adclrck transition always wins: it aborts any word in progress and
  // starts a new slot, whatever state we are in.
  always_comb begin
    state_next = state;
    latch_chan = 1'b0;
    cnt_clr    = 1'b0;
    shift_en   = 1'b0;
    word_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (lrck_toggle) begin
          state_next = ST_SKIP;
          latch_chan = 1'b1;
        end
      end
      ST_SKIP: begin
        if (lrck_toggle) begin
          state_next = ST_SKIP;
          latch_chan = 1'b1;
        end else if (bclk_rise) begin
          // I2S one-bit delay: this edge carries no data for the new slot
          state_next = ST_SHIFT;
          cnt_clr    = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (lrck_toggle) begin
          state_next = ST_SKIP;
          latch_chan = 1'b1;
        end else if (bclk_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            word_done  = 1'b1;
            state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (lrck_toggle) begin
          state_next = ST_SKIP;
          latch_chan = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or negedge ar) begin
    if (!ar) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      chan       <= 1'b0;
      left_buf   <= '0;
      left_valid <= 1'b0;
    end else begin
      if (latch_chan) begin
        chan <= lrck_sync;
      end
      if (cnt_clr) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (shift_en) begin
        shreg <= shreg_shifted;
      end
      if (word_done && !chan) begin
        left_buf <= shreg_shifted;
      end
      // A frame pairs a right word only with the left slot directly before it:
      // starting a new left slot forgets the old left word, and a finished
      // right word consumes it.
      if (latch_chan && !lrck_sync) begin
        left_valid <= 1'b0;
      end else if (word_done && !chan) begin
        left_valid <= 1'b1;
      end else if (word_done && chan) begin
        left_valid <= 1'b0;
      end
    end
  end

  // The right word goes straight from the shifter into the output register so
  // frame_valid rises the cycle after the last right bit is sampled.
  assign frame_done = word_done && chan && left_valid;
  assign xfer       = frame_valid && frame_ready;

`ifdef AUDIO_ADC_RX_BITCRUSH_EN
  always_comb begin
    crush_mask = '0;
    for (int i = 0; i < SAMPLE_W; i++) begin
      crush_mask[i] = (i >= int'(crush));
    end
  end
`else
  assign crush_mask = '1;
`endif

  always_ff @(posedge clk_50 or negedge ar) begin
    if (!ar) begin
      left_out    <= '0;
      right_out   <= '0;
      frame_valid <= 1'b0;
    end else begin
      if (frame_done && (!frame_valid || xfer)) begin
        left_out    <= left_buf & crush_mask;
        right_out   <= shreg_shifted & crush_mask;
        frame_valid <= 1'b1;
      end else if (xfer) begin
        frame_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_50 or negedge ar) begin
    if (!ar) begin
      overrun <= 1'b0;
    end else begin
      if (frame_done && frame_valid && !frame_ready) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: doc/audio_adc_rx.md
AUDIO_ADC_RX -- requirements
Module: audio_adc_rx

Interface
- REQ-001 Parameter SAMPLE_W, default 16: bits per channel sample.
- REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flops on each codec input.
- REQ-003 Port clk_50, input, 1: system clock, 50 MHz; all logic is in this domain.
- REQ-004 Port ar, input, 1: reset, asynchronous, active-low.
- REQ-005 Port bclk, input, 1: codec bit clock, asynchronous to clk_50, at most 1/8 of clk_50.
- REQ-006 Port adclrck, input, 1: codec ADC left/right clock; low selects left, high selects right.
- REQ-007 Port adcdat, input, 1: codec ADC serial data, I2S format, MSB first.
- REQ-008 Port frame_ready, input, 1: consumer accepts the frame when high while frame_valid is high.
- REQ-009 Port left_out, output, SAMPLE_W: left sample, two's complement.
- REQ-010 Port right_out, output, SAMPLE_W: right sample, two's complement.
- REQ-011 Port frame_valid, output, 1: a stereo frame is held on left_out/right_out.
- REQ-012 Port overrun, output, 1: sticky flag; a completed frame was dropped.
- REQ-013 Port overrun_clr, input, 1: clears overrun.

Function
- REQ-014 bclk, adclrck and adcdat SHALL each pass through SYNC_STAGES flops; all edge detection SHALL use the synchronized values.
- REQ-015 A bclk rising edge SHALL be detected as synchronized bclk high in the current cycle and low in the previous cycle, and SHALL be a single-cycle strobe.
- REQ-016 The FSM SHALL have four states: IDLE, SKIP, SHIFT and HOLD.
- REQ-017 IDLE: on any synchronized adclrck transition -> SKIP; the channel is latched from the new adclrck level.
- REQ-018 SKIP: the first bclk rising edge is ignored (I2S one-bit delay) -> SHIFT, bit counter = 0.
- REQ-019 SHIFT: on each bclk rising edge, synchronized adcdat SHALL be shifted into the channel shift register LSB-side, and the counter SHALL increment.
- REQ-020 SHIFT: after SAMPLE_W bits -> HOLD; the shift register SHALL be copied to the left or right buffer according to the latched channel.
- REQ-021 HOLD: extra bclk bits are ignored; an adclrck transition -> SKIP.
- REQ-022 An adclrck transition in SKIP or SHIFT SHALL abort the partial word: the word is discarded, the FSM goes to SKIP and the new channel is latched.
- REQ-023 Frame completion is a right word stored while a left word from the immediately preceding left slot is present.
- REQ-024 On frame completion, frame_valid SHALL assert one clk_50 cycle after the cycle in which the last right bit is sampled.
- REQ-025 left_out/right_out SHALL be stable while frame_valid is high.
- REQ-026 A transfer occurs when frame_valid and frame_ready are both high; frame_valid SHALL drop in the next cycle unless a new frame completes in that same cycle, in which case the new frame is loaded and frame_valid stays high.
- REQ-027 If a frame completes while frame_valid is high with no transfer, the new frame SHALL be dropped, the held frame kept, and overrun set.
- REQ-028 overrun_clr SHALL clear overrun; a simultaneous set SHALL win.
- REQ-029 A right word with no preceding left word (e.g. after reset) SHALL NOT produce a frame.

Reset
- REQ-030 While ar is low: FSM = IDLE; counter, shift register and buffers = 0; left_out = 0, right_out = 0, frame_valid = 0, overrun = 0; synchronizer flops = 0.
- REQ-031 Reset asserted mid-word or mid-handshake SHALL discard all data; after release, capture SHALL begin at the next adclrck transition.

Configuration
- REQ-032 With macro AUDIO_ADC_RX_BITCRUSH_EN defined, input crush[3:0] SHALL exist, and the low crush bits of both samples SHALL be zeroed when a frame is loaded (crush >= SAMPLE_W zeroes the whole sample).
- REQ-033 Without AUDIO_ADC_RX_BITCRUSH_EN, the crush port SHALL be absent and samples SHALL pass unmodified.

Structure
- REQ-034 Package audio_pkg SHALL hold the SAMPLE_W default, the FSM state enum and the stereo frame struct {left, right}.
- REQ-035 Sub-module i2s_sync SHALL implement the synchronizers and the bclk rise and adclrck toggle strobes.

Verification
- REQ-036 I2S model at bclk = 3.125 MHz, left 16'hA5C3, right 16'h1234, frame_ready = 1 -> one frame_valid pulse; left_out = A5C3, right_out = 1234.
- REQ-037 Two frames, left 16'h8000 / right 16'h7FFF then left 16'h0001 / right 16'hFFFF, with frame_ready = 0 -> first frame held, overrun = 1; overrun_clr pulse -> overrun = 0.
- REQ-038 adclrck toggled after 7 left bits -> partial word dropped; the following full frame is captured correctly.
- REQ-039 ar pulsed low mid right word -> all outputs 0; the next complete frame is captured correctly.
- REQ-040 24 bclk bits per slot -> only the first 16 are captured; values match the model.
- REQ-041 With AUDIO_ADC_RX_BITCRUSH_EN and crush = 4, left 16'hFFFF -> left_out = 16'hFFF0.
